// File: rtl/ifid_hazard_ctrl.sv
// Front-end hazard sequencer for the PC and IF/ID registers: load-use, redirect, MDU and memory-wait stalls.
// Optional IFID_PERF_CNT_EN adds saturating stall_cnt/flush_cnt counters.
module ifid_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int REG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    input  logic             ex_mdu_start,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
`endif
);

    // state    | meaning
    // RUN      | normal issue; hazard rules evaluated in priority order
    // MDU_WAIT | front end stalled while a multi-cycle MDU op occupies EX
    // MEM_WAIT | whole pipe frozen on data-memory wait
    localparam int CNT_W = $clog2(MDU_LAT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic load_use;
    logic redirect;
    logic pc_write_c, ifid_hold_c, ifid_flush_c, idex_flush_c, pipe_freeze_c;

    assign load_use = ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    assign redirect = id_branch_taken || id_jump;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        pc_write_c    = 1'b1;
        ifid_hold_c   = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        pipe_freeze_c = 1'b0;
        case (state_q)
            MDU_WAIT: begin
                pc_write_c  = 1'b0;
                ifid_hold_c = 1'b0;
                if (mem_busy) begin
                    pipe_freeze_c = 1'b1;
                end else begin
                    idex_flush_c = 1'b1;
                    // count holds the remaining wait cycles; leave on the last one
                    if (count_q <= CNT_W'(1)) begin
                        state_d = RUN;
                        count_d = '0;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                // MEM_WAIT with mem_busy low behaves exactly like RUN
                state_d = RUN;
                if (mem_busy) begin
                    pc_write_c    = 1'b0;
                    ifid_hold_c   = 1'b0;
                    pipe_freeze_c = 1'b1;
                    state_d       = MEM_WAIT;
                end else if (ex_mdu_start) begin
                    pc_write_c   = 1'b0;
                    ifid_hold_c  = 1'b0;
                    idex_flush_c = 1'b1;
                    count_d      = CNT_W'(MDU_LAT - 2);
                    state_d      = (MDU_LAT > 2) ? MDU_WAIT : RUN;
                end else if (load_use) begin
                    pc_write_c   = 1'b0;
                    ifid_hold_c  = 1'b0;
                    idex_flush_c = 1'b1;
                end else if (redirect) begin
                    ifid_hold_c  = 1'b0;
                    ifid_flush_c = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Outputs are forced low for as long as reset is held
    assign pc_write    = rst_n & pc_write_c;
    assign ifid_hold   = rst_n & ifid_hold_c;
    assign ifid_flush  = rst_n & ifid_flush_c;
    assign idex_flush  = rst_n & idex_flush_c;
    assign pipe_freeze = rst_n & pipe_freeze_c;

`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (ifid_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed scoreboard bench for ifid_hazard_ctrl (MDU_LAT=4, REG_W=5).
// Output vector order: {pc_write, ifid_hold, ifid_flush, idex_flush, pipe_freeze}.
module tb_ifid_hazard_ctrl;

    localparam logic [4:0] LOAD  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] REDIR = 5'b10100;
    localparam logic [4:0] MEMF  = 5'b00001;
    localparam logic [4:0] ZERO  = 5'b00000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, id_branch_taken, id_jump, ex_mdu_start, mem_busy;
    logic       pc_write, ifid_hold, ifid_flush, idex_flush, pipe_freeze;
`ifdef IFID_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    ifid_hazard_ctrl #(.MDU_LAT(4), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .id_branch_taken(id_branch_taken), .id_jump(id_jump),
        .ex_mdu_start(ex_mdu_start), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_freeze(pipe_freeze)
`ifdef IFID_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic mr, input logic [4:0] xrt, input logic br,
                         input logic jmp, input logic mdu, input logic busy);
        id_rs = rs; id_rt = rt; id_uses_rt = uses_rt;
        ex_mem_read = mr; ex_rt = xrt;
        id_branch_taken = br; id_jump = jmp;
        ex_mdu_start = mdu; mem_busy = busy;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_now();
        logic [4:0] obs;
        logic [4:0] e;
        string      t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {pc_write, ifid_hold, ifid_flush, idex_flush, pipe_freeze};
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", t, obs, e);
        end
    endtask

    task automatic expect_cycle(input logic [4:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

`ifdef IFID_PERF_CNT_EN
    task automatic check_cnt(input logic [15:0] obs, input logic [15:0] e, input string t);
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, e);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        expect_cycle(ZERO, "reset_hazard_inputs");
        idle();
        expect_cycle(ZERO, "reset_idle");
        rst_n = 1'b1;
        expect_cycle(LOAD, "first_after_reset");

        drive(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle(STALL, "load_use_rs");
        idle();
        expect_cycle(LOAD, "load_use_rs_clear");

        drive(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle(STALL, "load_use_rt");
        drive(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle(LOAD, "rt_match_not_used");

        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_cycle(LOAD, "ex_rt_zero");

        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cycle(REDIR, "branch_flush");
        idle();
        expect_cycle(LOAD, "branch_after");
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_cycle(REDIR, "jump_flush");

        drive(5'd6, 5'd2, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cycle(STALL, "branch_with_load_use");
        drive(5'd6, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cycle(REDIR, "branch_after_load_use");
        idle();
        expect_cycle(LOAD, "branch_load_use_done");

        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle(STALL, "mdu_entry");
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_cycle(STALL, "mdu_wait1_branch_held");
        expect_cycle(STALL, "mdu_wait2_branch_held");
        expect_cycle(REDIR, "mdu_done_branch");
        idle();
        expect_cycle(LOAD, "mdu_done_idle");

        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle(STALL, "mdu_busy_entry");
        idle();
        expect_cycle(STALL, "mdu_busy_wait1");
        mem_busy = 1'b1;
        expect_cycle(MEMF, "mdu_busy_freeze1");
        expect_cycle(MEMF, "mdu_busy_freeze2");
        mem_busy = 1'b0;
        expect_cycle(STALL, "mdu_busy_wait2");
        expect_cycle(LOAD, "mdu_busy_done");

        mem_busy = 1'b1;
        expect_cycle(MEMF, "mem_wait1");
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_cycle(MEMF, "mem_wait2_branch_held");
        mem_busy = 1'b0;
        expect_cycle(REDIR, "mem_exit_branch");
        idle();
        expect_cycle(LOAD, "mem_exit_idle");

        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_cycle(STALL, "rst_mdu_entry");
        idle();
        expect_cycle(STALL, "rst_mdu_wait1");
        rst_n = 1'b0;
        #1;
        exp_q.push_back(ZERO);
        tag_q.push_back("rst_async_outputs");
        check_now();
`ifdef IFID_PERF_CNT_EN
        check_cnt(stall_cnt, 16'd0, "rst_stall_cnt");
        check_cnt(flush_cnt, 16'd0, "rst_flush_cnt");
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_cycle(LOAD, "rst_release_run");
        expect_cycle(LOAD, "rst_release_run2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
